// File: rtl/deserializer_stream.sv
// Assembles NUM_WORDS words into one frame, with a valid/ready hold register, sticky overflow and flush.
// Optional inter-word timeout enabled by defining DESER_TIMEOUT_EN.
module deserializer_stream #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned NUM_WORDS      = 4,
  parameter bit          LITTLE_ENDIAN  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 4340
) (
  input  logic                               clk,
  input  logic                               i_reset,
  input  logic [WIDTH-1:0]                   i_data,
  input  logic                               i_dv,
  input  logic                               i_endian_ovr,
  input  logic                               i_little_endian,
  input  logic                               i_flush,
  output logic [WIDTH*NUM_WORDS-1:0]         o_data,
  output logic                               o_dv,
  input  logic                               i_ready,
  output logic                               o_busy,
  output logic [$clog2(NUM_WORDS+1)-1:0]     o_word_count,
  output logic                               o_overflow,
  input  logic                               i_clear_overflow,
  output logic                               o_timeout
);

  localparam int unsigned CW = $clog2(NUM_WORDS + 1);
  localparam int unsigned FW = WIDTH * NUM_WORDS;

  typedef enum logic {IDLE, ASSEMBLE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [FW-1:0]   asm_q, asm_d;
  logic [FW-1:0]   out_q, out_d;
  logic [FW-1:0]   frame;
  logic            endian_q, endian_d;
  logic            dv_q, dv_d;
  logic            ovf_q, ovf_d;
  logic            cur_le;
  logic            complete;
  logic            tmo_fire;
  int unsigned     pos;

`ifdef DESER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q;

  // An arriving word on the expiry cycle wins over the timeout.
  always_comb begin
    idle_d   = '0;
    tmo_fire = 1'b0;
    if (state_q == ASSEMBLE && !i_flush && !i_dv) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) tmo_fire = 1'b1;
      else                                   idle_d   = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= tmo_fire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign tmo_fire  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    asm_d    = asm_q;
    endian_d = endian_q;
    out_d    = out_q;
    dv_d     = dv_q;
    ovf_d    = ovf_q;
    complete = 1'b0;

    // Endianness is taken live only for the first word, then frozen for the frame.
    cur_le = (state_q == IDLE) ? (i_endian_ovr ? i_little_endian : LITTLE_ENDIAN) : endian_q;
    pos    = cur_le ? 32'(count_q) : (NUM_WORDS - 1 - 32'(count_q));
    frame  = asm_q;
    frame[pos*WIDTH +: WIDTH] = i_data;

    if (i_flush || tmo_fire) begin
      count_d = '0;
      asm_d   = '0;
    end else if (i_dv) begin
      if (state_q == IDLE) endian_d = cur_le;
      if (count_q == CW'(NUM_WORDS - 1)) begin
        complete = 1'b1;
        count_d  = '0;
        asm_d    = '0;
      end else begin
        count_d = count_q + 1'b1;
        asm_d   = frame;
      end
    end

    if (complete && (!dv_q || i_ready)) begin
      out_d = frame;
      dv_d  = 1'b1;
    end else if (dv_q && i_ready) begin
      dv_d = 1'b0;
    end

    if (i_clear_overflow)                 ovf_d = 1'b0;
    if (complete && dv_q && !i_ready)     ovf_d = 1'b1;

    state_d = (count_d == '0) ? IDLE : ASSEMBLE;
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      asm_q    <= '0;
      endian_q <= LITTLE_ENDIAN;
      out_q    <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      asm_q    <= asm_d;
      endian_q <= endian_d;
      out_q    <= out_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_data       = out_q;
  assign o_dv         = dv_q;
  assign o_busy       = (count_q != '0);
  assign o_word_count = count_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_deserializer_stream.sv
// Bench for deserializer_stream: queue-based frame model checked every cycle, plus literal expectations.
module tb_deserializer_stream;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_dv = 1'b0;
  logic        i_endian_ovr = 1'b0;
  logic        i_little_endian = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] o_data;
  logic        o_dv;
  logic        i_ready = 1'b1;
  logic        o_busy;
  logic [2:0]  o_word_count;
  logic        o_overflow;
  logic        i_clear_overflow = 1'b0;
  logic        o_timeout;

  int tests = 0;
  int fails = 0;

  deserializer_stream #(
    .WIDTH(8), .NUM_WORDS(4), .LITTLE_ENDIAN(1'b1), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_data(i_data), .i_dv(i_dv),
    .i_endian_ovr(i_endian_ovr), .i_little_endian(i_little_endian),
    .i_flush(i_flush), .o_data(o_data), .o_dv(o_dv), .i_ready(i_ready),
    .o_busy(o_busy), .o_word_count(o_word_count), .o_overflow(o_overflow),
    .i_clear_overflow(i_clear_overflow), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words collected in arrival order, frame built once complete.
  logic [7:0]  q[$];
  logic        m_le = 1'b1;
  logic [31:0] m_out = '0;
  logic        m_dv = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_tmo = 1'b0;
  int          m_idle = 0;

  function automatic logic [31:0] build(input logic le);
    logic [31:0] f = '0;
    for (int k = 0; k < 4; k++) begin
      if (le) f[k*8 +: 8]       = q[k];
      else    f[(3-k)*8 +: 8]   = q[k];
    end
    return f;
  endfunction

  always @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      q.delete();
      m_le = 1'b1; m_out = '0; m_dv = 1'b0; m_ovf = 1'b0; m_tmo = 1'b0; m_idle = 0;
    end else begin
      logic old_dv, fire, complete;
      logic [31:0] fr;
      old_dv = m_dv; fire = 1'b0; complete = 1'b0; fr = '0;
`ifdef DESER_TIMEOUT_EN
      if (q.size() > 0 && !i_flush && !i_dv) begin
        m_idle++;
        if (m_idle == 10) begin fire = 1'b1; m_idle = 0; end
      end else m_idle = 0;
`endif
      if (i_flush || fire) q.delete();
      else if (i_dv) begin
        if (q.size() == 0) m_le = i_endian_ovr ? i_little_endian : 1'b1;
        q.push_back(i_data);
        if (q.size() == 4) begin
          fr = build(m_le);
          q.delete();
          complete = 1'b1;
        end
      end
      if (complete && (!old_dv || i_ready)) begin m_out = fr; m_dv = 1'b1; end
      else if (old_dv && i_ready) m_dv = 1'b0;
      if (i_clear_overflow) m_ovf = 1'b0;
      if (complete && old_dv && !i_ready) m_ovf = 1'b1;
      m_tmo = fire;
    end
  end

  always @(negedge clk) begin
    chk("o_data", o_data, m_out);
    chk("o_dv", 32'(o_dv), 32'(m_dv));
    chk("o_word_count", 32'(o_word_count), 32'(q.size()));
    chk("o_busy", 32'(o_busy), 32'(q.size() != 0));
    chk("o_overflow", 32'(o_overflow), 32'(m_ovf));
    chk("o_timeout", 32'(o_timeout), 32'(m_tmo));
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    i_dv = 1'b1; i_data = b; i_flush = 1'b0; i_clear_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_dv = 1'b0; i_flush = 1'b0; i_clear_overflow = 1'b0;
    end
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #2;
    i_dv = 1'b0;
    i_reset = 1'b0;
    #1;
    chk({nm, "_rst_data"}, o_data, 32'h0);
    chk({nm, "_rst_dv"}, 32'(o_dv), 32'h0);
    chk({nm, "_rst_busy"}, 32'(o_busy), 32'h0);
    chk({nm, "_rst_cnt"}, 32'(o_word_count), 32'h0);
    chk({nm, "_rst_ovf"}, 32'(o_overflow), 32'h0);
    chk({nm, "_rst_tmo"}, 32'(o_timeout), 32'h0);
    @(negedge clk);
    i_reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_data", o_data, 32'h0);
    chk("reset_dv", 32'(o_dv), 32'h0);
    i_reset = 1'b1;

    // Little-endian from parameter
    i_ready = 1'b1;
    send(8'haa); send(8'h00); send(8'hbb); send(8'hcc);
    idle(1);
    chk("le_data", o_data, 32'hccbb00aa);
    chk("le_dv", 32'(o_dv), 32'h1);
    idle(1);
    chk("le_dv_drop", 32'(o_dv), 32'h0);

    // Big-endian override; select toggled mid-frame must be ignored
    i_endian_ovr = 1'b1; i_little_endian = 1'b0;
    send(8'haa); send(8'h00);
    i_little_endian = 1'b1;
    send(8'hbb); send(8'hcc);
    idle(1);
    chk("be_data", o_data, 32'haa00bbcc);
    i_endian_ovr = 1'b0;
    idle(1);

    // Overflow with consumer stalled
    i_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(1);
    chk("hold_data", o_data, 32'h44332211);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    idle(1);
    chk("ovf_data", o_data, 32'h44332211);
    chk("ovf_flag", 32'(o_overflow), 32'h1);
    i_ready = 1'b1;
    idle(1);
    chk("ovf_dv_drop", 32'(o_dv), 32'h0);
    @(negedge clk); i_clear_overflow = 1'b1;
    idle(1);
    chk("ovf_clear", 32'(o_overflow), 32'h0);

    // Flush coinciding with i_dv
    send(8'haa); send(8'hbb);
    @(negedge clk);
    chk("flush_cnt_before", 32'(o_word_count), 32'h2);
    i_flush = 1'b1; i_dv = 1'b1; i_data = 8'hcc;
    idle(1);
    chk("flush_cnt_after", 32'(o_word_count), 32'h0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(1);
    chk("flush_data", o_data, 32'h04030201);

    // Inter-word idle gap
    send(8'haa);
    idle(12);
`ifdef DESER_TIMEOUT_EN
    chk("gap_cnt", 32'(o_word_count), 32'h0);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(1);
    chk("gap_data", o_data, 32'h04030201);
`else
    chk("gap_cnt", 32'(o_word_count), 32'h1);
    send(8'h01); send(8'h02); send(8'h03);
    idle(1);
    chk("gap_data", o_data, 32'h030201aa);
    send(8'h04);
    @(negedge clk); i_dv = 1'b0; i_flush = 1'b1;
    idle(1);
`endif

    // Async reset mid-frame, then while holding output
    send(8'h11); send(8'h22);
    async_reset_check("midframe");
    i_ready = 1'b0;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(1);
    chk("pre_rst_dv", 32'(o_dv), 32'h1);
    async_reset_check("midhold");
    i_ready = 1'b1;
    send(8'hde); send(8'had); send(8'hbe); send(8'hef);
    idle(1);
    chk("post_rst_data", o_data, 32'hefbeadde);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
